regfile_operand_fetch: RTL and testbench

- Initiator side of the 32x32 register file interface. Accepts decoded instructions (rs, rt, rd) and drives the regfile read-address ports.
- Returns both source operands through a one-stage registered output with valid/ready handshake.
- Drives the regfile write port from the writeback bus.
- Tracks pending destination registers in a scoreboard: stalls on RAW/WAW hazards and bypasses same-cycle writeback data.

---
 rtl/regfile_operand_fetch_pkg.sv | 33 +++
 rtl/regfile_operand_fetch_scoreboard.sv | 57 +++++
 rtl/regfile_operand_fetch.sv | 95 +++++++++
 tb/tb_regfile_operand_fetch.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_operand_fetch_pkg.sv
// Shared constants, operand bundle type and operand-select helper for the
// register-file operand fetch stage.
package regfile_pkg;

  localparam int NREG  = 32;
  localparam int WIDTH = 32;
  localparam int AW    = $clog2(NREG);

  localparam logic [AW-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [AW-1:0]    rd;
    logic             rd_en;
  } bundle_t;

  // r0 is hardwired to zero; a same-cycle writeback overrides the stale regfile value.
  function automatic logic [WIDTH-1:0] selectOperand(
    input logic [AW-1:0]    r,
    input logic             wbValid,
    input logic [AW-1:0]    wbRd,
    input logic [WIDTH-1:0] wbData,
    input logic [WIDTH-1:0] rfData
  );
    logic [WIDTH-1:0] sel;
    if (r == ZERO_REG)                 sel = '0;
    else if (wbValid && (wbRd == r))   sel = wbData;
    else                               sel = rfData;
    return sel;
  endfunction

endpackage

// File: rtl/regfile_operand_fetch_scoreboard.sv
// Busy-register scoreboard: tracks in-flight destinations, counts them and
// flags writebacks that target a register nobody was waiting on.
module rf_scoreboard
  import regfile_pkg::*;
(
  input  logic          clock,
  input  logic          ctrl_reset,
  input  logic          wbValid,
  input  logic [AW-1:0] wbRd,
  input  logic          setEn,
  input  logic [AW-1:0] setRd,
  input  logic [AW-1:0] qRs,
  input  logic [AW-1:0] qRt,
  input  logic [AW-1:0] qRd,
  output logic          qBusyRs,
  output logic          qBusyRt,
  output logic          qBusyRd,
  output logic [AW:0]   pendingCnt,
  output logic          wbErr
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busyNext;
  logic [AW:0]     cntNext;

  // A register being written back this cycle no longer blocks its readers.
  assign qBusyRs = busy[qRs] & ~(wbValid & (wbRd == qRs));
  assign qBusyRt = busy[qRt] & ~(wbValid & (wbRd == qRt));
  assign qBusyRd = busy[qRd] & ~(wbValid & (wbRd == qRd));

  // Clear first, then set, so a WAW reissue in the writeback cycle keeps the entry busy.
  always_comb begin
    busyNext = busy;
    if (wbValid) busyNext[wbRd] = 1'b0;
    if (setEn && (setRd != ZERO_REG)) busyNext[setRd] = 1'b1;
  end

  always_comb begin
    cntNext = '0;
    for (int i = 0; i < NREG; i++) begin
      cntNext = cntNext + {{AW{1'b0}}, busyNext[i]};
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      busy       <= '0;
      pendingCnt <= '0;
      wbErr      <= 1'b0;
    end else begin
      busy       <= busyNext;
      pendingCnt <= cntNext;
      if (wbValid && (wbRd != ZERO_REG) && !busy[wbRd]) wbErr <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_operand_fetch.sv
// Operand fetch stage in front of a 32x32 register file: hazard stall,
// writeback bypass and a one-deep registered operand bundle.
module regfile_operand_fetch
  import regfile_pkg::*;
(
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_rs,
  input  logic [AW-1:0]    in_rt,
  input  logic [AW-1:0]    in_rd,
  input  logic             in_rd_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_opA,
  output logic [WIDTH-1:0] out_opB,
  output logic [AW-1:0]    out_rd,
  output logic             out_rd_en,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  output logic [AW-1:0]    rf_readRegA,
  output logic [AW-1:0]    rf_readRegB,
  input  logic [WIDTH-1:0] rf_readDataA,
  input  logic [WIDTH-1:0] rf_readDataB,
  output logic             rf_writeEnable,
  output logic [AW-1:0]    rf_writeReg,
  output logic [WIDTH-1:0] rf_writeData,
  output logic [AW:0]      pending_cnt,
  output logic             wb_err
);

  logic    busyRs;
  logic    busyRt;
  logic    busyRd;
  logic    hazard;
  logic    issue;
  logic    outValidQ;
  bundle_t bundleQ;
  bundle_t bundleNext;

  assign rf_readRegA    = in_rs;
  assign rf_readRegB    = in_rt;
  assign rf_writeEnable = wb_valid & (wb_rd != ZERO_REG) & ~ctrl_reset;
  assign rf_writeReg    = wb_rd;
  assign rf_writeData   = wb_data;

  rf_scoreboard uScoreboard (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .wbValid    (wb_valid),
    .wbRd       (wb_rd),
    .setEn      (issue & in_rd_en),
    .setRd      (in_rd),
    .qRs        (in_rs),
    .qRt        (in_rt),
    .qRd        (in_rd),
    .qBusyRs    (busyRs),
    .qBusyRt    (busyRt),
    .qBusyRd    (busyRd),
    .pendingCnt (pending_cnt),
    .wbErr      (wb_err)
  );

  assign hazard   = busyRs | busyRt | (in_rd_en & busyRd);
  assign in_ready = ~ctrl_reset & ~hazard & (~outValidQ | out_ready);
  assign issue    = in_valid & in_ready;

  always_comb begin
    bundleNext.opA   = selectOperand(in_rs, wb_valid, wb_rd, wb_data, rf_readDataA);
    bundleNext.opB   = selectOperand(in_rt, wb_valid, wb_rd, wb_data, rf_readDataB);
    bundleNext.rd    = in_rd;
    bundleNext.rd_en = in_rd_en;
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      outValidQ <= 1'b0;
      bundleQ   <= '0;
    end else if (issue) begin
      outValidQ <= 1'b1;
      bundleQ   <= bundleNext;
    end else if (out_ready) begin
      outValidQ <= 1'b0;
    end
  end

  assign out_valid = outValidQ;
  assign out_opA   = bundleQ.opA;
  assign out_opB   = bundleQ.opB;
  assign out_rd    = bundleQ.rd;
  assign out_rd_en = bundleQ.rd_en;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Self-checking bench for regfile_operand_fetch: directed scenarios plus a
// randomized run against a behavioural register-file/scoreboard model.
module tb_regfile_operand_fetch;

  localparam int NR = 32;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        in_valid, in_ready, in_rd_en;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic        out_valid, out_ready, out_rd_en;
  logic [31:0] out_opA, out_opB;
  logic [4:0]  out_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  rf_readRegA, rf_readRegB, rf_writeReg;
  logic [31:0] rf_readDataA, rf_readDataB, rf_writeData;
  logic        rf_writeEnable;
  logic [5:0]  pending_cnt;
  logic        wb_err;

  regfile_operand_fetch dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_rd_en(in_rd_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_opA(out_opA), .out_opB(out_opB),
    .out_rd(out_rd), .out_rd_en(out_rd_en),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_readRegA(rf_readRegA), .rf_readRegB(rf_readRegB),
    .rf_readDataA(rf_readDataA), .rf_readDataB(rf_readDataB),
    .rf_writeEnable(rf_writeEnable), .rf_writeReg(rf_writeReg), .rf_writeData(rf_writeData),
    .pending_cnt(pending_cnt), .wb_err(wb_err)
  );

  always #5 clock = ~clock;

  // Environment register file, written through the DUT write port or by preload.
  logic [31:0] envMem [NR];
  logic        loadEn;
  logic [4:0]  loadAddr;
  logic [31:0] loadData;
  always @(posedge clock) begin
    if (rf_writeEnable)  envMem[rf_writeReg] <= rf_writeData;
    else if (loadEn)     envMem[loadAddr]    <= loadData;
  end
  assign rf_readDataA = envMem[rf_readRegA];
  assign rf_readDataB = envMem[rf_readRegB];

  // Reference model state
  bit          refBusy [NR];
  logic [31:0] refMem  [NR];
  logic        refOutValid, refRdEn, refErr;
  logic [31:0] refOpA, refOpB;
  logic [4:0]  refRd;

  logic        expReady, expWe, obsReady, obsWe;
  logic [4:0]  obsRegA, obsRegB, obsWReg;
  logic [31:0] obsWData;

  int checks = 0;
  int failures = 0;

  function automatic int refPending();
    int n = 0;
    for (int i = 0; i < NR; i++) n += refBusy[i] ? 1 : 0;
    return n;
  endfunction

  task automatic modelClear();
    for (int i = 0; i < NR; i++) refBusy[i] = 1'b0;
    refOutValid = 0; refOpA = 0; refOpB = 0; refRd = 0; refRdEn = 0; refErr = 0;
  endtask

  // One clock: drive inputs at the falling edge, sample combinational outputs,
  // advance the model at the rising edge, then settle for registered checks.
  task automatic step(input logic rst, input logic iv, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic rdEn,
                      input logic outRdy, input logic wbv, input logic [4:0] wbrd,
                      input logic [31:0] wbd);
    logic bA, bB, bD, issue;
    logic [31:0] eA, eB;
    @(negedge clock);
    ctrl_reset = rst; in_valid = iv; in_rs = rs; in_rt = rt; in_rd = rd; in_rd_en = rdEn;
    out_ready = outRdy; wb_valid = wbv; wb_rd = wbrd; wb_data = wbd;
    #1;
    bA = refBusy[rs] && !(wbv && wbrd == rs);
    bB = refBusy[rt] && !(wbv && wbrd == rt);
    bD = refBusy[rd] && !(wbv && wbrd == rd);
    expReady = !rst && !(bA || bB || (rdEn && bD)) && (!refOutValid || outRdy);
    expWe    = wbv && (wbrd != 0) && !rst;
    eA = (rs == 0) ? 32'h0 : ((wbv && wbrd == rs) ? wbd : refMem[rs]);
    eB = (rt == 0) ? 32'h0 : ((wbv && wbrd == rt) ? wbd : refMem[rt]);
    obsReady = in_ready; obsWe = rf_writeEnable;
    obsRegA = rf_readRegA; obsRegB = rf_readRegB; obsWReg = rf_writeReg; obsWData = rf_writeData;
    @(posedge clock);
    if (rst) begin
      modelClear();
    end else begin
      issue = iv && expReady;
      if (wbv && wbrd != 0 && !refBusy[wbrd]) refErr = 1;
      if (wbv) refBusy[wbrd] = 0;
      if (issue && rdEn && rd != 0) refBusy[rd] = 1;
      if (wbv && wbrd != 0) refMem[wbrd] = wbd;
      if (issue) begin
        refOutValid = 1; refOpA = eA; refOpB = eB; refRd = rd; refRdEn = rdEn;
      end else if (outRdy) begin
        refOutValid = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    ctrl_reset = 1; in_valid = 1; in_rs = 1; in_rt = 2; in_rd = 3; in_rd_en = 1;
    out_ready = 0; wb_valid = 1; wb_rd = 5'd9; wb_data = 32'h1234_5678; loadEn = 1;
    loadAddr = 0; loadData = 0;
    for (int i = 0; i < NR; i++) begin
      @(negedge clock);
      v = (i == 0) ? 32'hFFFF_FFFF : (i == 1) ? 32'h11 : (i == 2) ? 32'h22 : $urandom;
      loadAddr = 5'(i); loadData = v; refMem[i] = v;
    end
    @(negedge clock);
    loadEn = 0;
    #1;
    modelClear();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (rf_writeEnable !== 1'b0) begin failures++; $display("FAIL reset_we: got %b want 0", rf_writeEnable); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_opA !== 32'h0 || out_opB !== 32'h0) begin failures++; $display("FAIL reset_ops: got %h/%h want 0/0", out_opA, out_opB); end
    checks++; if (out_rd !== 5'd0 || out_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd: got %0d/%b want 0/0", out_rd, out_rd_en); end
    checks++; if (pending_cnt !== 6'd0) begin failures++; $display("FAIL reset_pending: got %0d want 0", pending_cnt); end
    checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL reset_wb_err: got %b want 0", wb_err); end
  endtask

  task automatic test_basic();
    step(0, 1, 1, 2, 3, 1, 1, 0, 0, 0);
    checks++; if (obsReady !== 1'b1) begin failures++; $display("FAIL basic_ready: got %b want 1", obsReady); end
    checks++; if (obsRegA !== 5'd1 || obsRegB !== 5'd2) begin failures++; $display("FAIL basic_raddr: got %0d/%0d want 1/2", obsRegA, obsRegB); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    checks++; if (out_opA !== 32'h11 || out_opB !== 32'h22) begin failures++; $display("FAIL basic_ops: got %h/%h want 11/22", out_opA, out_opB); end
    checks++; if (out_rd !== 5'd3 || out_rd_en !== 1'b1) begin failures++; $display("FAIL basic_rd: got %0d/%b want 3/1", out_rd, out_rd_en); end
    checks++; if (pending_cnt !== 6'd1) begin failures++; $display("FAIL basic_pending: got %0d want 1", pending_cnt); end
  endtask

  task automatic test_bypass();
    step(0, 1, 3, 4, 0, 0, 1, 0, 0, 0);
    checks++; if (obsReady !== 1'b0) begin failures++; $display("FAIL raw_stall: got %b want 0", obsReady); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_valid: got %b want 0", out_valid); end
    step(0, 1, 3, 4, 0, 0, 1, 1, 3, 32'hDEAD);
    checks++; if (obsReady !== 1'b1) begin failures++; $display("FAIL bypass_ready: got %b want 1", obsReady); end
    checks++; if (obsWe !== 1'b1 || obsWReg !== 5'd3 || obsWData !== 32'hDEAD) begin failures++; $display("FAIL bypass_wport: got %b/%0d/%h want 1/3/dead", obsWe, obsWReg, obsWData); end
    checks++; if (out_opA !== 32'hDEAD) begin failures++; $display("FAIL bypass_opA: got %h want dead", out_opA); end
    checks++; if (out_opB !== refMem[4]) begin failures++; $display("FAIL bypass_opB: got %h want %h", out_opB, refMem[4]); end
    checks++; if (pending_cnt !== 6'd0) begin failures++; $display("FAIL bypass_pending: got %0d want 0", pending_cnt); end
  endtask

  task automatic test_zero_reg();
    step(0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    checks++; if (out_opA !== 32'h0 || out_opB !== 32'h0) begin failures++; $display("FAIL r0_ops: got %h/%h want 0/0", out_opA, out_opB); end
    checks++; if (pending_cnt !== 6'd0) begin failures++; $display("FAIL r0_pending: got %0d want 0", pending_cnt); end
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0BAD);
    checks++; if (obsWe !== 1'b0) begin failures++; $display("FAIL r0_we: got %b want 0", obsWe); end
    checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL r0_wb_err: got %b want 0", wb_err); end
  endtask

  task automatic test_hold();
    step(0, 1, 1, 2, 4, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 5, 6, 8, 1, 0, 0, 0, 0);
      checks++; if (obsReady !== 1'b0) begin failures++; $display("FAIL hold_ready: got %b want 0", obsReady); end
      checks++; if (out_valid !== 1'b1 || out_rd !== 5'd4 || out_opA !== 32'h11 || out_opB !== 32'h22)
        begin failures++; $display("FAIL hold_stable: got v=%b rd=%0d %h/%h want 1/4 11/22", out_valid, out_rd, out_opA, out_opB); end
    end
    step(0, 1, 5, 6, 8, 1, 1, 0, 0, 0);
    checks++; if (obsReady !== 1'b1) begin failures++; $display("FAIL release_ready: got %b want 1", obsReady); end
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd8 || out_opA !== refMem[5] || out_opB !== refMem[6])
      begin failures++; $display("FAIL release_bundle: got rd=%0d %h/%h want 8 %h/%h", out_rd, out_opA, out_opB, refMem[5], refMem[6]); end
    checks++; if (pending_cnt !== 6'd2) begin failures++; $display("FAIL release_pending: got %0d want 2", pending_cnt); end
    step(0, 0, 0, 0, 0, 0, 1, 1, 4, $urandom);
    step(0, 0, 0, 0, 0, 0, 1, 1, 8, $urandom);
    checks++; if (pending_cnt !== 6'd0) begin failures++; $display("FAIL hold_cleanup: got %0d want 0", pending_cnt); end
  endtask

  task automatic test_waw();
    step(0, 1, 1, 2, 5, 1, 1, 0, 0, 0);
    step(0, 1, 1, 2, 5, 1, 1, 1, 5, 32'h5555);
    checks++; if (obsReady !== 1'b1) begin failures++; $display("FAIL waw_ready: got %b want 1", obsReady); end
    checks++; if (pending_cnt !== 6'd1) begin failures++; $display("FAIL waw_pending: got %0d want 1", pending_cnt); end
    step(0, 1, 5, 0, 0, 0, 1, 0, 0, 0);
    checks++; if (obsReady !== 1'b0) begin failures++; $display("FAIL waw_still_busy: got %b want 0", obsReady); end
    step(0, 0, 0, 0, 0, 0, 1, 1, 7, 32'h7777);
    checks++; if (wb_err !== 1'b1) begin failures++; $display("FAIL wb_err_set: got %b want 1", wb_err); end
    step(0, 0, 0, 0, 0, 0, 1, 1, 5, 32'h5A5A);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    checks++; if (wb_err !== 1'b1 || pending_cnt !== 6'd0) begin failures++; $display("FAIL wb_err_sticky: got %b/%0d want 1/0", wb_err, pending_cnt); end
  endtask

  task automatic test_random();
    logic iv, rdEn, outRdy, wbv;
    logic [4:0] rs, rt, rd, wbrd;
    int busyList[$];
    for (int n = 0; n < 400; n++) begin
      iv = 1'($urandom_range(0, 3) != 0);
      rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
      rdEn = 1'($urandom_range(0, 3) != 0);
      outRdy = 1'($urandom_range(0, 3) != 0);
      busyList.delete();
      for (int r = 1; r < 8; r++) if (refBusy[r]) busyList.push_back(r);
      wbv = 0; wbrd = 0;
      if (busyList.size() > 0 && $urandom_range(0, 1) == 1) begin
        wbv = 1; wbrd = 5'(busyList[$urandom_range(0, busyList.size() - 1)]);
      end else if ($urandom_range(0, 9) == 0) begin
        wbv = 1; wbrd = 5'($urandom_range(0, 7));
      end
      step(0, iv, rs, rt, rd, rdEn, outRdy, wbv, wbrd, $urandom);
      checks++; if (obsReady !== expReady) begin failures++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, obsReady, expReady); end
      checks++; if (obsWe !== expWe) begin failures++; $display("FAIL rnd_we[%0d]: got %b want %b", n, obsWe, expWe); end
      checks++; if (obsRegA !== rs || obsRegB !== rt) begin failures++; $display("FAIL rnd_raddr[%0d]: got %0d/%0d want %0d/%0d", n, obsRegA, obsRegB, rs, rt); end
      checks++; if (out_valid !== refOutValid) begin failures++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, out_valid, refOutValid); end
      if (refOutValid) begin
        checks++; if (out_opA !== refOpA || out_opB !== refOpB || out_rd !== refRd || out_rd_en !== refRdEn)
          begin failures++; $display("FAIL rnd_bundle[%0d]: got %h/%h/%0d/%b want %h/%h/%0d/%b", n, out_opA, out_opB, out_rd, out_rd_en, refOpA, refOpB, refRd, refRdEn); end
      end
      checks++; if (pending_cnt !== 6'(refPending())) begin failures++; $display("FAIL rnd_pending[%0d]: got %0d want %0d", n, pending_cnt, refPending()); end
      checks++; if (wb_err !== refErr) begin failures++; $display("FAIL rnd_wb_err[%0d]: got %b want %b", n, wb_err, refErr); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 10; i < 14; i++) step(0, 1, 0, 0, 5'(i), 1, 1, 0, 0, 0);
    checks++; if (out_valid !== 1'b1 || pending_cnt !== 6'(refPending()) || refPending() < 4)
      begin failures++; $display("FAIL mid_setup: got v=%b pend=%0d want 1/%0d", out_valid, pending_cnt, refPending()); end
    step(1, 1, 1, 2, 3, 1, 1, 1, 10, 32'hCAFE);
    checks++; if (obsReady !== 1'b0 || obsWe !== 1'b0) begin failures++; $display("FAIL mid_reset_comb: got rdy=%b we=%b want 0/0", obsReady, obsWe); end
    checks++; if (out_valid !== 1'b0 || pending_cnt !== 6'd0 || wb_err !== 1'b0 || out_opA !== 32'h0)
      begin failures++; $display("FAIL mid_reset_state: got v=%b pend=%0d err=%b opA=%h want 0/0/0/0", out_valid, pending_cnt, wb_err, out_opA); end
    step(0, 1, 10, 11, 12, 1, 1, 0, 0, 0);
    checks++; if (obsReady !== 1'b1 || out_opA !== refMem[10]) begin failures++; $display("FAIL post_reset_issue: got rdy=%b opA=%h want 1/%h", obsReady, out_opA, refMem[10]); end
  endtask

  initial begin
    ctrl_reset = 1; in_valid = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_rd_en = 0;
    out_ready = 0; wb_valid = 0; wb_rd = 0; wb_data = 0;
    loadEn = 0; loadAddr = 0; loadData = 0;
    test_reset();
    test_basic();
    test_bypass();
    test_zero_reg();
    test_hold();
    test_waw();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
